// File: rtl/cpu_run_ctrl_if.sv
// Command, program-load and instruction-memory write signals of cpu_run_ctrl.
// master drives commands and program words; slave is the controller.
interface cpu_run_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       load_valid;
    logic       load_ready;
    logic [1:0] load_data;
    logic       imem_we;
    logic [1:0] imem_addr;
    logic [1:0] imem_wdata;

    modport master (
        output cmd_valid, cmd_op, load_valid, load_data,
        input  cmd_ready, load_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_op, load_valid, load_data,
        output cmd_ready, load_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller: loads a program into instruction memory, then primes and clocks the CPU.
// Define CPU_RUN_CTRL_STEP_EN to compile in single-step (STEP command) support.
module cpu_run_ctrl #(
    parameter int PROG_DEPTH = 4,
    parameter int RUN_LEN    = 4
) (
    input  logic          clk,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus,
    output logic          cpu_reset,
    output logic          cpu_clk_en,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          prog_loaded,
    output logic [2:0]    state
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_LOAD  = 3'b001,
        ST_PRIME = 3'b010,
        ST_RUN   = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_ABORT = 2'b11
    } op_t;

    localparam logic [1:0] LAST_WORD  = 2'(PROG_DEPTH - 1);
    localparam logic [3:0] RUN_CYCLES = 4'(RUN_LEN);

    state_t     state_q, state_d;
    logic [1:0] word_cnt_q, word_cnt_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       prog_loaded_q, prog_loaded_d;
    logic       err_q, err_d;
    logic       imem_we_q, imem_we_d;
    logic [1:0] imem_addr_q, imem_addr_d;
    logic [1:0] imem_wdata_q, imem_wdata_d;

    logic       idle_like;
    logic       abort_offered;
    logic       cmd_fire;
    logic       beat;

    // ABORT is always accepted and blocks a coincident load beat.
    assign idle_like      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign abort_offered  = bus.cmd_valid && (bus.cmd_op == OP_ABORT);
    assign bus.cmd_ready  = idle_like || (bus.cmd_op == OP_ABORT);
    assign bus.load_ready = (state_q == ST_LOAD) && !abort_offered;
    assign cmd_fire       = bus.cmd_valid && bus.cmd_ready;
    assign beat           = bus.load_valid && bus.load_ready;

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        run_cnt_d     = run_cnt_q;
        prog_loaded_d = prog_loaded_q;
        err_d         = 1'b0;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;

        if (cmd_fire && (bus.cmd_op == OP_ABORT)) begin
            state_d   = ST_IDLE;
            run_cnt_d = '0;
        end else if (cmd_fire) begin
            case (bus.cmd_op)
                OP_LOAD: begin
                    state_d       = ST_LOAD;
                    word_cnt_d    = '0;
                    prog_loaded_d = 1'b0;
                end
                OP_RUN: begin
                    if (prog_loaded_q) begin
                        state_d   = ST_PRIME;
                        run_cnt_d = RUN_CYCLES;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STEP: begin
`ifdef CPU_RUN_CTRL_STEP_EN
                    // Stepping from DONE keeps CPU state, so it skips PRIME.
                    if (state_q == ST_DONE) begin
                        state_d   = ST_RUN;
                        run_cnt_d = 4'd1;
                    end else if (prog_loaded_q) begin
                        state_d   = ST_PRIME;
                        run_cnt_d = 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    err_d = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (beat) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q;
                        imem_wdata_d = bus.load_data;
                        word_cnt_d   = word_cnt_q + 2'd1;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d       = ST_IDLE;
                            prog_loaded_d = 1'b1;
                        end
                    end
                end
                ST_PRIME: state_d = ST_RUN;
                ST_RUN: begin
                    run_cnt_d = (run_cnt_q == 4'd0) ? 4'd0 : run_cnt_q - 4'd1;
                    if (run_cnt_q <= 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            word_cnt_q    <= '0;
            run_cnt_q     <= '0;
            prog_loaded_q <= 1'b0;
            err_q         <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            run_cnt_q     <= run_cnt_d;
            prog_loaded_q <= prog_loaded_d;
            err_q         <= err_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
        end
    end

    assign cpu_reset      = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_PRIME);
    assign cpu_clk_en     = (state_q == ST_RUN);
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign prog_loaded    = prog_loaded_q;
    assign state          = state_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios then random traffic, all checked
// against a phase-level behavioural model. Honours CPU_RUN_CTRL_STEP_EN like the DUT.
module tb_cpu_run_ctrl;
    localparam int PROG_DEPTH = 4;
    localparam int RUN_LEN    = 4;
`ifdef CPU_RUN_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_reset, cpu_clk_en, busy, done, err, prog_loaded;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int en_seen = 0;

    // Model: which phase the controller is in, expressed as plain flags and counts.
    bit         m_valid = 1'b0;
    bit         m_loading, m_prime, m_done, m_prog, m_err, m_we;
    int         m_words, m_run_left, m_pending;
    logic [1:0] m_addr, m_wdata;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(.PROG_DEPTH(PROG_DEPTH), .RUN_LEN(RUN_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .prog_loaded(prog_loaded),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check handshake readies, advance model, check registered outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic lv,
                                 input logic [1:0] ld, input logic rst);
        bit         idle_like, exp_cmd_ready, exp_load_ready, fire, beat;
        logic [2:0] exp_state;
        @(negedge clk);
        bus.cmd_valid  = v;
        bus.cmd_op     = op;
        bus.load_valid = lv;
        bus.load_data  = ld;
        reset          = rst;
        #1;
        idle_like      = !m_loading && !m_prime && (m_run_left == 0);
        exp_cmd_ready  = idle_like || (op == 2'b11);
        exp_load_ready = m_loading && !(v && (op == 2'b11));
        fire           = v && exp_cmd_ready;
        beat           = lv && exp_load_ready;
        if (m_valid) begin
            checkOutput("cmd_ready", {3'b000, bus.cmd_ready}, {3'b000, exp_cmd_ready});
            checkOutput("load_ready", {3'b000, bus.load_ready}, {3'b000, exp_load_ready});
        end

        m_err = 1'b0;
        m_we  = 1'b0;
        if (rst) begin
            m_loading = 0; m_prime = 0; m_done = 0; m_prog = 0;
            m_words = 0; m_run_left = 0; m_pending = 0;
            m_addr = 2'b00; m_wdata = 2'b00;
            m_valid = 1'b1;
        end else if (fire && (op == 2'b11)) begin
            m_loading = 0; m_prime = 0; m_run_left = 0; m_done = 0;
        end else if (fire) begin
            case (op)
                2'b00: begin
                    m_loading = 1; m_words = 0; m_prog = 0; m_done = 0;
                end
                2'b01: begin
                    if (m_prog) begin
                        m_prime = 1; m_pending = RUN_LEN; m_done = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                default: begin
                    if (!STEP_EN) m_err = 1;
                    else if (m_done) begin
                        m_run_left = 1; m_done = 0;
                    end else if (m_prog) begin
                        m_prime = 1; m_pending = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            endcase
        end else if (m_loading) begin
            if (beat) begin
                m_we    = 1;
                m_addr  = m_words[1:0];
                m_wdata = ld;
                m_words++;
                if (m_words == PROG_DEPTH) begin
                    m_loading = 0; m_prog = 1;
                end
            end
        end else if (m_prime) begin
            m_prime    = 0;
            m_run_left = m_pending;
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) m_done = 1;
        end

        exp_state = m_loading ? 3'd1 : m_prime ? 3'd2 : (m_run_left > 0) ? 3'd3 : m_done ? 3'd4 : 3'd0;

        @(posedge clk);
        #1;
        if (bus.imem_we === 1'b1) writes_seen++;
        if (cpu_clk_en === 1'b1) en_seen++;
        checkOutput("state", {1'b0, state}, {1'b0, exp_state});
        checkOutput("cpu_reset", {3'b000, cpu_reset}, {3'b000, !((m_run_left > 0) || m_done)});
        checkOutput("cpu_clk_en", {3'b000, cpu_clk_en}, {3'b000, (m_run_left > 0)});
        checkOutput("busy", {3'b000, busy}, {3'b000, (m_loading || m_prime || (m_run_left > 0))});
        checkOutput("done", {3'b000, done}, {3'b000, m_done});
        checkOutput("err", {3'b000, err}, {3'b000, m_err});
        checkOutput("prog_loaded", {3'b000, prog_loaded}, {3'b000, m_prog});
        checkOutput("imem_we", {3'b000, bus.imem_we}, {3'b000, m_we});
        checkOutput("imem_addr", {2'b00, bus.imem_addr}, {2'b00, m_addr});
        checkOutput("imem_wdata", {2'b00, bus.imem_wdata}, {2'b00, m_wdata});
    endtask

    initial begin
        logic [3:0] words [4];
        words[0] = 4'h1; words[1] = 4'h3; words[2] = 4'h0; words[3] = 4'h0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
        bus.load_valid = 1'b0; bus.load_data = 2'b00;
        reset = 1'b1;

        $display("[TB] reset");
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);

        $display("[TB] RUN with no program");
        en_seen = 0;
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        checkOutput("norun_clk_en_count", 4'(en_seen), 4'd0);

        $display("[TB] program load 01,11,00,00");
        writes_seen = 0;
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 1'b1, words[i][1:0], 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        checkOutput("load_write_count", 4'(writes_seen), 4'd4);

        $display("[TB] RUN then STEP x2");
        en_seen = 0;
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        checkOutput("run_clk_en_count", 4'(en_seen), 4'(RUN_LEN));
        en_seen = 0;
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
            applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
            applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        end
        checkOutput("step_clk_en_count", 4'(en_seen), STEP_EN ? 4'd2 : 4'd0);

        $display("[TB] LOAD two beats then ABORT with beat offered");
        writes_seen = 0;
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1, 2'b11, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
        checkOutput("abort_write_count", 4'(writes_seen), 4'd2);

        $display("[TB] reset during RUN");
        applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b00, 1'b1, 2'(i), 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic       v, lv, rst;
            logic [1:0] op;
            int         r;
            r   = $urandom_range(0, 9);
            op  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            v   = ($urandom_range(0, 2) == 0);
            lv  = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(v, op, lv, 2'($urandom_range(0, 3)), rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter PROG_DEPTH, default 4, number of instruction words per program load (1..4).
REQ-002 Parameter RUN_LEN, default 4, number of CPU clock-enable cycles per RUN command (1..15).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-006 cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT.
REQ-007 load_valid  in  1  / load_ready  out  1  / load_data  in  2  program word handshake.
REQ-008 imem_we  out  1  / imem_addr  out  2  / imem_wdata  out  2  instruction-memory write port.
REQ-009 cpu_reset  out  1  reset to the CPU; cpu_clk_en  out  1  CPU advance enable.
REQ-010 busy  out  1  / done  out  1  / err  out  1  / prog_loaded  out  1  status.
REQ-011 state  out  3  current FSM state encoding: IDLE 000, LOAD 001, PRIME 010, RUN 011, DONE 100.

Function
REQ-012 cmd_ready SHALL be 1 in IDLE and DONE for all ops, and 1 in every state for ABORT.
REQ-013 Accepted command at edge T SHALL take effect in state visible after edge T.
REQ-014 LOAD: IDLE/DONE -> LOAD; word counter cleared; prog_loaded cleared.
REQ-015 load_ready SHALL be 1 only in LOAD and not while ABORT is offered (cmd_valid && cmd_op==11).
REQ-016 Each accepted beat SHALL drive imem_we=1, imem_addr=counter, imem_wdata=load_data one cycle later (registered), then counter+1.
REQ-017 After beat PROG_DEPTH-1 accepted: LOAD -> IDLE, prog_loaded=1 one cycle later.
REQ-018 RUN with prog_loaded=0 SHALL be consumed, produce err=1 for exactly one cycle, state unchanged.
REQ-019 RUN with prog_loaded=1: -> PRIME; PRIME lasts 1 cycle with cpu_reset=1, cpu_clk_en=0; -> RUN.
REQ-020 RUN: cpu_reset=0, cpu_clk_en=1 for exactly RUN_LEN consecutive cycles (4-bit down-counter, no wrap past 0); -> DONE.
REQ-021 DONE: cpu_clk_en=0, cpu_reset=0 (CPU state held), done=1 until the next accepted command.
REQ-022 cpu_reset SHALL be 1 in IDLE, LOAD and PRIME; 0 in RUN and DONE.
REQ-023 busy SHALL be 1 in LOAD, PRIME, RUN; 0 otherwise.
REQ-024 ABORT from any state: -> IDLE next cycle, cpu_clk_en=0; if aborted in LOAD, prog_loaded stays 0; otherwise prog_loaded unchanged.
REQ-025 ABORT in same cycle as a load beat: ABORT wins, beat not written, no imem_we.
REQ-026 LOAD with load_valid stalled SHALL wait indefinitely with no writes.
REQ-027 err SHALL pulse one cycle for any command not permitted by REQ-012/018/033; never otherwise.

Reset
REQ-028 On reset=1 at a posedge, next state SHALL be IDLE regardless of current state, including mid-LOAD and mid-RUN.
REQ-029 Reset values: cpu_reset=1, all other outputs 0 (cmd_ready=1 per REQ-012, load_ready=0), prog_loaded=0, counters 0.
REQ-030 reset SHALL dominate any simultaneous command or load beat.

Configuration
REQ-031 Macro CPU_RUN_CTRL_STEP_EN compiles in single-step support.
REQ-032 Defined: STEP accepted in DONE SHALL give cpu_clk_en=1 for exactly one cycle then return to DONE (no PRIME).
REQ-033 Defined: STEP accepted in IDLE with prog_loaded=1 SHALL run PRIME, one enable cycle, then DONE; with prog_loaded=0 -> err.
REQ-034 Not defined: STEP SHALL always be rejected with one-cycle err pulse; no state change.

Verification
REQ-035 Load words 01,11,00,00 back-to-back -> imem_we 4 cycles, addr 0,1,2,3, data 01,11,00,00; prog_loaded=1; state IDLE.
REQ-036 RUN (RUN_LEN=4) accepted at T -> cpu_reset=1 at T+1, cpu_clk_en=1 T+2..T+5, done=1 from T+6.
REQ-037 RUN after reset with no load -> err=1 one cycle, state stays 000, cpu_clk_en never 1.
REQ-038 LOAD, 2 beats, then ABORT with load_valid=1 -> IDLE, only 2 imem writes, prog_loaded=0.
REQ-039 STEP_EN defined: after REQ-036 DONE, two STEPs -> two isolated single-cycle cpu_clk_en pulses, cpu_reset stays 0; undefined: err pulse each.
REQ-040 reset asserted at cycle 2 of RUN -> next cycle state 000, cpu_reset=1, cpu_clk_en=0, prog_loaded=0.
